exec_wb_queue: RTL and testbench
================================

# exec_wb_queue

Buffers execution-unit results between the ALU/branch unit and the writeback stage. Writeback gives the LSU priority and drops any exec result presented while `lsu_wb_valid` is high, so this queue holds each result until writeback actually grants it. The queue presents results to writeback in order and applies backpressure to the execution unit when full. It flushes on pipeline redirect and raises an anti-starvation hold request toward the LSU.

## Interface
- `DEPTH`, 4: queue entries; must be a power of two, ≥2.
- `STARVE_LIMIT`, 8: consecutive denied cycles of the head entry before `lsu_hold` asserts; ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  pipeline redirect; discard all queued results.
- `alu_valid`  in  1  result offered by the execution unit.
- `alu_ready`  out  1  queue can accept; equals `!full && !flush`.
- `alu_rob_idx`  in  ROB_IDX_W  ROB index of the result.
- `alu_phys_rd`  in  PHYS_REG_IDX_W  destination physical register.
- `alu_result`  in  INT_DATA_W  result data.
- `alu_is_branch`, `alu_branch_taken`  in  1 each  branch info.
- `alu_branch_target`  in  INSTR_MEM_IDX_W  resolved target.
- `lsu_wb_valid`  in  1  the same signal writeback arbitrates on; high means exec is denied this cycle.
- `exec_valid`  out  1  head result presented to writeback.
- `exec_rob_idx`, `exec_phys_rd`, `exec_result`, `exec_is_branch`, `exec_branch_taken`, `exec_branch_target`  out  widths as the `alu_*` inputs  head entry fields.
- `lsu_hold`  out  1  request that the LSU withhold writeback next cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Push:** `alu_valid && alu_ready`. Write the entry at the tail; tail advances modulo DEPTH.
- **Pop:** `exec_valid && !lsu_wb_valid && !flush`. Head advances modulo DEPTH. This matches the writeback grant exactly.
- **Push and pop in the same cycle:** both take effect, and `count` is unchanged. The queue is never full when pushing, so no overwrite can occur.
- **Outputs:** `exec_valid = (count != 0) && !flush`. The exec fields come from the head entry. When `exec_valid` is 0, all fields are driven to 0.
- **Flush:**
  - Next edge: head, tail, count and age all go to 0.
  - Flush cycle: push is blocked (`alu_ready`=0) and `exec_valid` is masked.
- **Starvation age counter:** saturates at STARVE_LIMIT.
  - Clears on pop, flush, or when empty.
  - Increments each cycle that `exec_valid && lsu_wb_valid`.
- **`lsu_hold`:** `(age >= STARVE_LIMIT) && exec_valid`. It drops the cycle after the head pops.
- **Reset values:** count 0, pointers 0, age 0, `exec_valid` 0, exec fields 0, `lsu_hold` 0, `alu_ready` 1 once `rst` deasserts (0 while `rst` is high).

## Timing
- **Latency without bypass:** a result pushed at edge N is presented from cycle N+1. Minimum ALU-to-writeback latency is 1 cycle.
- **Outputs:** `exec_*` come from registered storage plus the combinational flush mask. `alu_ready` is registered-full gated by `flush`.
- **Occupancy limits:** full at `count==DEPTH`; empty at `count==0`. Pointers wrap from DEPTH-1 to 0.
- **Reset mid-operation:** all contents are lost immediately (asynchronous reset). No partial entry survives.

## Configuration
- **`EXEC_WB_BYPASS_EN` defined:** when `count==0`, `alu_valid`, `!lsu_wb_valid` and `!flush`, the `alu_*` fields drive `exec_*` combinationally and the result is not written to the queue. This gives zero-cycle latency.
  - In that cycle `exec_valid`=1 and `count` stays 0.
  - If `lsu_wb_valid` is high, the normal push path is used.
- **Undefined:** no combinational ALU-to-exec path; the minimum latency is 1 cycle.

## Structure
- **Shared package `general_defines`:**
  - Add `exec_wb_entry_t`, a packed struct of rob_idx, phys_rd, result, is_branch, branch_taken, branch_target.
  - Existing widths ROB_IDX_W, PHYS_REG_IDX_W, INT_DATA_W and INSTR_MEM_IDX_W are reused.
- **Sub-module `exec_wb_fifo_mem`:** a DEPTH × `exec_wb_entry_t` register array with write port (we, waddr, wdata) and asynchronous read at the head pointer.
  - It has no reset; validity is tracked by `count` only.
- **Top level:** pointers, count, age counter, bypass mux and flush.

## Test plan
- **Basic latency:** push rob_idx=3, result=0x1234 with `lsu_wb_valid`=0.
  - Without bypass: `exec_valid`=1 with result 0x1234 the next cycle, then `count` returns to 0.
  - With bypass: same-cycle presentation and `count` stays 0.
- **Ordering under LSU priority:** hold `lsu_wb_valid`=1 and push rob_idx 1,2,3,4.
  - `count`=4, `alu_ready`=0, and a 5th push is refused.
  - Release LSU: pops occur in order 1,2,3,4 on consecutive cycles.
- **Simultaneous push/pop:** with `count`=2, push and pop in the same cycle.
  - `count` stays 2 and FIFO order is preserved across the pointer wrap (tail 3→0).
- **Flush:** with `count`=3, assert `flush` together with `alu_valid`.
  - `exec_valid`=0 and `alu_ready`=0 that cycle; `count`=0 next cycle; the flushed push is not stored.
- **Starvation hold:** head valid with `lsu_wb_valid`=1 for 8 cycles (STARVE_LIMIT=8).
  - `lsu_hold` rises after the 8th denied cycle.
  - Drop `lsu_wb_valid`: the head pops and `lsu_hold`=0 the following cycle.
- **Reset mid-operation:** assert `rst` with `count`=2 and age=5.
  - `exec_valid`, `lsu_hold` and `count` go to 0 immediately.
  - After release, the first push appears as normal.

Source files
------------

// File: rtl/general_defines.sv
// general_defines: shared pipeline widths and the exec-to-writeback entry record
package general_defines;
    localparam int ROB_IDX_W       = 5;
    localparam int PHYS_REG_IDX_W  = 6;
    localparam int INT_DATA_W      = 32;
    localparam int INSTR_MEM_IDX_W = 10;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]       rob_idx;
        logic [PHYS_REG_IDX_W-1:0]  phys_rd;
        logic [INT_DATA_W-1:0]      result;
        logic                       is_branch;
        logic                       branch_taken;
        logic [INSTR_MEM_IDX_W-1:0] branch_target;
    } exec_wb_entry_t;
endpackage

// File: rtl/exec_wb_fifo_mem.sv
// exec_wb_fifo_mem: DEPTH x exec_wb_entry_t storage, one write port, async read.
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read.
// No reset: entry validity is tracked by the owner's occupancy count.
module exec_wb_fifo_mem
    import general_defines::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  exec_wb_entry_t wdata,
    input  logic [AW-1:0]  raddr,
    output exec_wb_entry_t rdata
);
    exec_wb_entry_t r_mem [DEPTH];

    always_ff @(posedge clk)
        if (we) r_mem[waddr] <= wdata;

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/exec_wb_queue.sv
// exec_wb_queue: in-order buffer of exec results until writeback grants them.
// Ports: clk, rst (async high), flush; alu_* producer side with alu_ready;
// lsu_wb_valid (writeback denial); exec_* head presentation; lsu_hold; count.
// EXEC_WB_BYPASS_EN: when defined, an empty queue forwards alu_* straight to
// exec_* in the same cycle if writeback will accept it.
module exec_wb_queue
    import general_defines::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ROB_IDX_W-1:0]       alu_rob_idx,
    input  logic [PHYS_REG_IDX_W-1:0]  alu_phys_rd,
    input  logic [INT_DATA_W-1:0]      alu_result,
    input  logic                       alu_is_branch,
    input  logic                       alu_branch_taken,
    input  logic [INSTR_MEM_IDX_W-1:0] alu_branch_target,
    input  logic                       lsu_wb_valid,
    output logic                       exec_valid,
    output logic [ROB_IDX_W-1:0]       exec_rob_idx,
    output logic [PHYS_REG_IDX_W-1:0]  exec_phys_rd,
    output logic [INT_DATA_W-1:0]      exec_result,
    output logic                       exec_is_branch,
    output logic                       exec_branch_taken,
    output logic [INSTR_MEM_IDX_W-1:0] exec_branch_target,
    output logic                       lsu_hold,
    output logic [CW-1:0]              count
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] AGE_MAX = SW'(STARVE_LIMIT);

    logic [AW-1:0]  r_head, r_tail;
    logic [CW-1:0]  r_count;
    logic [SW-1:0]  r_age;
    exec_wb_entry_t w_in, w_head, w_out;
    logic           w_full, w_q_valid, w_byp, w_push, w_pop;

    assign w_in = '{alu_rob_idx, alu_phys_rd, alu_result, alu_is_branch,
                    alu_branch_taken, alu_branch_target};

    assign w_full    = r_count == CW'(DEPTH);
    assign w_q_valid = (r_count != '0) && !flush;
`ifdef EXEC_WB_BYPASS_EN
    assign w_byp = (r_count == '0) && alu_valid && !lsu_wb_valid && !flush;
`else
    assign w_byp = 1'b0;
`endif
    assign alu_ready = !rst && !w_full && !flush;
    // a bypassed result is consumed by writeback directly and never stored
    assign w_push = alu_valid && alu_ready && !w_byp;
    assign w_pop  = w_q_valid && !lsu_wb_valid;

    assign exec_valid = w_q_valid || w_byp;
    assign w_out = w_byp ? w_in : (w_q_valid ? w_head : '0);
    assign {exec_rob_idx, exec_phys_rd, exec_result, exec_is_branch,
            exec_branch_taken, exec_branch_target} = w_out;
    assign lsu_hold = (r_age >= AGE_MAX) && exec_valid;
    assign count    = r_count;

    exec_wb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_tail),
        .wdata (w_in),
        .raddr (r_head),
        .rdata (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_age   <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop) r_head <= r_head + AW'(1);
            if (w_push && !w_pop) r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
            // age measures how long the current head has been denied
            r_age <= (w_pop || r_count == '0) ? '0 :
                     (lsu_wb_valid && r_age != AGE_MAX) ? r_age + SW'(1) : r_age;
        end
    end
endmodule

// File: tb/tb_exec_wb_queue.sv
// tb_exec_wb_queue: table vectors, directed corner sequences and a random run
// checked against a queue-based reference model.
module tb_exec_wb_queue;
    import general_defines::*;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 0, rst = 1, flush = 0, alu_valid = 0, lsu_wb_valid = 0;
    logic alu_ready, exec_valid, lsu_hold;
    logic [ROB_IDX_W-1:0]       alu_rob_idx = 0, exec_rob_idx;
    logic [PHYS_REG_IDX_W-1:0]  alu_phys_rd = 0, exec_phys_rd;
    logic [INT_DATA_W-1:0]      alu_result = 0, exec_result;
    logic                       alu_is_branch = 0, alu_branch_taken = 0;
    logic                       exec_is_branch, exec_branch_taken;
    logic [INSTR_MEM_IDX_W-1:0] alu_branch_target = 0, exec_branch_target;
    logic [CW-1:0]              count;

    int n_checks = 0, n_fail = 0;

    exec_wb_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rob_idx(alu_rob_idx), .alu_phys_rd(alu_phys_rd),
        .alu_result(alu_result), .alu_is_branch(alu_is_branch),
        .alu_branch_taken(alu_branch_taken), .alu_branch_target(alu_branch_target),
        .lsu_wb_valid(lsu_wb_valid),
        .exec_valid(exec_valid), .exec_rob_idx(exec_rob_idx),
        .exec_phys_rd(exec_phys_rd), .exec_result(exec_result),
        .exec_is_branch(exec_is_branch), .exec_branch_taken(exec_branch_taken),
        .exec_branch_target(exec_branch_target),
        .lsu_hold(lsu_hold), .count(count)
    );

    always #5 clk = ~clk;

    // reference model: a plain queue of pending results plus a denial age
    exec_wb_entry_t mq[$];
    int m_age = 0;
    logic e_byp, e_ready, e_valid, e_hold;
    exec_wb_entry_t e_ent;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exec_wb_entry_t in_ent();
        return '{alu_rob_idx, alu_phys_rd, alu_result, alu_is_branch,
                 alu_branch_taken, alu_branch_target};
    endfunction

    function automatic exec_wb_entry_t out_ent();
        return '{exec_rob_idx, exec_phys_rd, exec_result, exec_is_branch,
                 exec_branch_taken, exec_branch_target};
    endfunction

    task automatic sample();
        @(negedge clk);
`ifdef EXEC_WB_BYPASS_EN
        e_byp = mq.size() == 0 && alu_valid && !lsu_wb_valid && !flush;
`else
        e_byp = 0;
`endif
        e_ready = mq.size() < DEPTH && !flush;
        e_valid = (mq.size() > 0 && !flush) || e_byp;
        e_ent = e_byp ? in_ent() : ((mq.size() > 0 && !flush) ? mq[0] : '0);
        e_hold = m_age >= LIMIT && e_valid;
        check("model_ready", 64'(alu_ready), 64'(e_ready));
        check("model_valid", 64'(exec_valid), 64'(e_valid));
        check("model_entry", 64'(out_ent()), 64'(e_ent));
        check("model_hold", 64'(lsu_hold), 64'(e_hold));
        check("model_count", 64'(count), 64'(mq.size()));
    endtask

    task automatic advance();
        bit was_empty, pop, push;
        exec_wb_entry_t ent;
        ent = in_ent();
        was_empty = mq.size() == 0;
        pop = !was_empty && !flush && !lsu_wb_valid;
        push = alu_valid && e_ready && !e_byp;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_age = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(ent);
            m_age = (pop || was_empty) ? 0 : (lsu_wb_valid && m_age < LIMIT) ? m_age + 1 : m_age;
        end
        #1;
    endtask

    task automatic drive(input bit av, input bit lsu, input bit fl, input int rob, input int res);
        alu_valid = av;
        lsu_wb_valid = lsu;
        flush = fl;
        alu_rob_idx = ROB_IDX_W'(rob);
        alu_result = INT_DATA_W'(res);
        alu_phys_rd = PHYS_REG_IDX_W'(rob + 7);
        alu_is_branch = rob[0];
        alu_branch_taken = rob[1];
        alu_branch_target = INSTR_MEM_IDX_W'(rob * 3);
    endtask

    typedef struct {
        bit av, lsu;
        int rob;
        bit x_valid, x_ready;
        int x_count, x_rob;
    } vec_t;
    vec_t vt[11];

    initial begin
        // ordering under LSU priority, fill to DEPTH, refuse 5th, drain in order
        vt[0]  = '{0, 0, 0, 0, 1, 0, 0};
        vt[1]  = '{1, 1, 1, 0, 1, 0, 0};
        vt[2]  = '{1, 1, 2, 1, 1, 1, 1};
        vt[3]  = '{1, 1, 3, 1, 1, 2, 1};
        vt[4]  = '{1, 1, 4, 1, 1, 3, 1};
        vt[5]  = '{1, 1, 5, 1, 0, 4, 1};
        vt[6]  = '{0, 0, 0, 1, 0, 4, 1};
        vt[7]  = '{0, 0, 0, 1, 1, 3, 2};
        vt[8]  = '{0, 0, 0, 1, 1, 2, 3};
        vt[9]  = '{0, 0, 0, 1, 1, 1, 4};
        vt[10] = '{0, 0, 0, 0, 1, 0, 0};

        #2;
        check("reset_ready", 64'(alu_ready), 64'(0));
        check("reset_valid", 64'(exec_valid), 64'(0));
        check("reset_count", 64'(count), 64'(0));
        check("reset_hold", 64'(lsu_hold), 64'(0));
        check("reset_result", 64'(exec_result), 64'(0));
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].av, vt[i].lsu, 0, vt[i].rob, 100 + vt[i].rob);
            sample();
            check($sformatf("tbl%0d_valid", i), 64'(exec_valid), 64'(vt[i].x_valid));
            check($sformatf("tbl%0d_ready", i), 64'(alu_ready), 64'(vt[i].x_ready));
            check($sformatf("tbl%0d_count", i), 64'(count), 64'(vt[i].x_count));
            check($sformatf("tbl%0d_rob", i), 64'(exec_rob_idx), 64'(vt[i].x_rob));
            advance();
        end

        // basic latency
        drive(1, 0, 0, 3, 32'h1234);
        sample();
`ifdef EXEC_WB_BYPASS_EN
        check("lat_byp_valid", 64'(exec_valid), 64'(1));
        check("lat_byp_result", 64'(exec_result), 64'h1234);
`else
        check("lat_valid0", 64'(exec_valid), 64'(0));
`endif
        advance();
        drive(0, 0, 0, 0, 0);
        sample();
`ifndef EXEC_WB_BYPASS_EN
        check("lat_valid1", 64'(exec_valid), 64'(1));
        check("lat_result", 64'(exec_result), 64'h1234);
        check("lat_rob", 64'(exec_rob_idx), 64'(3));
`endif
        advance();
        sample();
        check("lat_count", 64'(count), 64'(0));
        advance();

        // simultaneous push/pop holding count at 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin drive(1, 1, 0, 10 + i, i); sample(); advance(); end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 12 + i, i);
            sample();
            check("pp_count", 64'(count), 64'(2));
            check("pp_rob", 64'(exec_rob_idx), 64'(10 + i));
            advance();
        end
        drive(0, 0, 0, 0, 0);
        repeat (3) begin sample(); advance(); end

        // flush with count 3 and a concurrent push
        for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 20 + i, i); sample(); advance(); end
        drive(1, 0, 1, 23, 0);
        sample();
        check("flush_valid", 64'(exec_valid), 64'(0));
        check("flush_ready", 64'(alu_ready), 64'(0));
        advance();
        drive(0, 0, 0, 0, 0);
        sample();
        check("flush_count", 64'(count), 64'(0));
        check("flush_valid_after", 64'(exec_valid), 64'(0));
        advance();

        // starvation hold
        drive(1, 1, 0, 30, 30);
        sample(); advance();
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < LIMIT; i++) begin
            sample();
            check($sformatf("starve%0d_hold", i), 64'(lsu_hold), 64'(0));
            advance();
        end
        drive(0, 0, 0, 0, 0);
        sample();
        check("starve_hold_up", 64'(lsu_hold), 64'(1));
        advance();
        sample();
        check("starve_hold_down", 64'(lsu_hold), 64'(0));
        check("starve_count", 64'(count), 64'(0));
        advance();

        // reset mid-operation
        for (int i = 0; i < 2; i++) begin drive(1, 1, 0, 40 + i, i); sample(); advance(); end
        drive(0, 1, 0, 0, 0);
        repeat (4) begin sample(); advance(); end
        rst = 1;
        #1;
        check("rst_valid", 64'(exec_valid), 64'(0));
        check("rst_hold", 64'(lsu_hold), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_ready", 64'(alu_ready), 64'(0));
        mq.delete();
        m_age = 0;
        @(posedge clk); #1;
        rst = 0;
        drive(1, 0, 0, 7, 32'h77);
        sample(); advance();
        drive(0, 0, 0, 0, 0);
        sample();
        check("rst_first_push", 64'(exec_valid), 64'(1));
        check("rst_first_rob", 64'(exec_rob_idx), 64'(7));
        advance();

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            alu_valid = 1'($urandom_range(0, 1));
            lsu_wb_valid = $urandom_range(0, 99) < 55;
            flush = $urandom_range(0, 99) < 4;
            alu_rob_idx = ROB_IDX_W'($urandom);
            alu_phys_rd = PHYS_REG_IDX_W'($urandom);
            alu_result = $urandom;
            alu_is_branch = 1'($urandom);
            alu_branch_taken = 1'($urandom);
            alu_branch_target = INSTR_MEM_IDX_W'($urandom);
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
